fifo_rd_skid: RTL and testbench
===============================

Name: fifo_rd_skid

Overview:
Downstream read stage for the dual-write first-word-fall-through FIFO. It pops words using the FIFO's data_avail/r_val/r_data interface and presents them on a registered valid/ready output through a 2-entry skid buffer. The FIFO pop strobe depends only on local registered state, never on out_rdy, which breaks the ready timing path into the FIFO.

Parameters:
WIDTH, 64, data word width; matches the FIFO's FIFO_WIDTH.
XFER_CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset; asynchronous, active-high
flush  in  1  synchronous clear of buffered words
in_data_avail  in  1  FIFO has a word on in_data (fall-through)
in_data  in  WIDTH  FIFO r_data
in_r_val  out  1  pop strobe to FIFO r_val
out_val  out  1  output word valid
out_data  out  WIDTH  output word (head entry)
out_rdy  in  1  consumer accepts out_data when out_val=1
xfer_cnt  out  XFER_CNT_WIDTH  words delivered since reset; saturating
occupancy  out  2  buffered words, 0..2

Behaviour:
- Reset (async, rst=1): occupancy=0, out_val=0, out_data=all ones, skid register=all ones, xfer_cnt=0, in_r_val=0.
- Storage: head register drives out_data; skid register holds the second word. out_val = (occupancy != 0), decoded from registered state.
- Pop rule: in_r_val = in_data_avail & (occupancy != 2) & ~flush.
  - Purely from registered occupancy and inputs; no combinational path from out_rdy.
  - A word is captured in the same cycle in_r_val=1 (fall-through data valid that cycle).
- Output transfer: pop_out = out_val & out_rdy.
- Occupancy transitions (push = in_r_val):
  - 0, push: head<=in_data, occ 1.
  - 1, push, no pop_out: skid<=in_data, occ 2.
  - 1, push, pop_out: head<=in_data, occ 1. This gives full throughput.
  - 1, pop_out only: occ 0; head keeps its stale value.
  - 2, pop_out: head<=skid, occ 1. Push is impossible at occ 2.
  - 2, no pop_out: hold.
- Latency: FIFO word to out_val is 1 cycle. Sustained 1 word/cycle when out_rdy is held high.
- Ordering: strict FIFO; head is always older than skid.
- xfer_cnt:
  - Increments by 1 on each pop_out.
  - Saturates at all ones and does not wrap.
  - Not cleared by flush.
- flush=1:
  - occupancy<=0 next cycle; any pop_out in the same cycle is still counted.
  - in_r_val forced 0.
  - Data registers are not cleared.
- Reset mid-transfer: buffered words are lost. The FIFO is reset alongside, so no pop is generated while rst=1.
- out_data while out_val=0: holds the last value. Consumers must not sample it.
- The FIFO's ELEM_NONE output is never captured, because in_r_val requires in_data_avail.

Decomposition:
- Shared package: WIDTH default; reset data pattern (all ones, same as FIFO ELEM_NONE); occupancy encodings OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2.
- No sub-module needed. Optionally split out the saturating counter as sat_counter (parameter XFER_CNT_WIDTH, input inc, output value).

Test Plan:
- Reset, then in_data_avail=1 with in_data=0x11, out_rdy=1 -> in_r_val=1 in cycle 0; out_val=1, out_data=0x11 in cycle 1; xfer_cnt=1 after cycle 1.
- Streaming 0x01..0x08, one per cycle, out_rdy=1 throughout -> 8 consecutive out_val cycles, in order, no bubbles; occupancy never exceeds 1; xfer_cnt=8.
- out_rdy=0 with words 0xA,0xB,0xC available -> 0xA, 0xB captured, occupancy=2, in_r_val=0 while 0xC waits. Then out_rdy=1 -> outputs 0xA, 0xB, 0xC in order.
- Occupancy 2 (0x5,0x6) and flush=1 with out_rdy=1 -> 0x5 counted (xfer_cnt+1); next cycle occupancy=0, out_val=0; in_r_val=0 during flush.
- XFER_CNT_WIDTH=4, 20 transfers -> xfer_cnt stops at 15.
- rst asserted asynchronously mid-cycle at occupancy 2 -> out_val falls immediately; occupancy=0 and xfer_cnt=0 without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_rd_skid_pkg.sv
// Shared constants for the FIFO read-side skid stage: default width and
// occupancy encodings of the 2-entry buffer.
package fifo_rd_skid_pkg;

  localparam int DEF_WIDTH          = 64;
  localparam int DEF_XFER_CNT_WIDTH = 16;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage

// File: rtl/fifo_rd_skid_sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all ones.
module sat_counter #(
  parameter int XFER_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inc,
  output logic [XFER_CNT_WIDTH-1:0] value
);

  localparam logic [XFER_CNT_WIDTH-1:0] ONE = XFER_CNT_WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     value <= '0;
    else if (inc && value != '1) value <= value + ONE;
  end

endmodule

// File: rtl/fifo_rd_skid.sv
// Read stage behind the FWFT FIFO: pops on local state only and presents
// words through a 2-entry head/skid buffer on a valid/ready output.
module fifo_rd_skid
  import fifo_rd_skid_pkg::*;
#(
  parameter int WIDTH          = DEF_WIDTH,
  parameter int XFER_CNT_WIDTH = DEF_XFER_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_data_avail,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_r_val,
  output logic                      out_val,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      out_rdy,
  output logic [XFER_CNT_WIDTH-1:0] xfer_cnt,
  output logic [1:0]                occupancy
);

  logic [1:0]       occ;
  logic [WIDTH-1:0] head, skid;
  logic             push, pop_out;

  // Pop depends only on registered occupancy, never on out_rdy.
  assign in_r_val  = in_data_avail & (occ != OCC_TWO) & ~flush & ~rst;
  assign push      = in_r_val;
  assign out_val   = (occ != OCC_EMPTY);
  assign pop_out   = out_val & out_rdy;
  assign out_data  = head;
  assign occupancy = occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ  <= OCC_EMPTY;
      head <= '1;
      skid <= '1;
    end else if (flush) begin
      occ <= OCC_EMPTY;
    end else begin
      case (occ)
        OCC_EMPTY: if (push) begin
          head <= in_data;
          occ  <= OCC_ONE;
        end
        OCC_ONE: begin
          if (push && pop_out) head <= in_data;
          else if (push) begin
            skid <= in_data;
            occ  <= OCC_TWO;
          end else if (pop_out) occ <= OCC_EMPTY;
        end
        OCC_TWO: if (pop_out) begin
          head <= skid;
          occ  <= OCC_ONE;
        end
        default: occ <= OCC_EMPTY;
      endcase
    end
  end

  sat_counter #(.XFER_CNT_WIDTH(XFER_CNT_WIDTH)) u_xfer_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pop_out),
    .value (xfer_cnt)
  );

endmodule

// File: tb/tb_fifo_rd_skid.sv
// Directed + random bench for fifo_rd_skid with a queue scoreboard of buffered words.
module tb_fifo_rd_skid;

  logic        clk = 1'b0;
  logic        rst, flush, in_data_avail, out_rdy;
  logic [63:0] in_data;
  logic        in_r_val, out_val;
  logic [63:0] out_data;
  logic [15:0] xfer_cnt;
  logic [1:0]  occupancy;
  logic        in_r_val4, out_val4;
  logic [63:0] out_data4;
  logic [3:0]  xfer_cnt4;
  logic [1:0]  occupancy4;

  logic [63:0] q[$];
  int          m_cnt;
  int          total = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  fifo_rd_skid #(.WIDTH(64), .XFER_CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_data_avail(in_data_avail),
    .in_data(in_data), .in_r_val(in_r_val), .out_val(out_val),
    .out_data(out_data), .out_rdy(out_rdy), .xfer_cnt(xfer_cnt),
    .occupancy(occupancy)
  );

  fifo_rd_skid #(.WIDTH(64), .XFER_CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_data_avail(in_data_avail),
    .in_data(in_data), .in_r_val(in_r_val4), .out_val(out_val4),
    .out_data(out_data4), .out_rdy(out_rdy), .xfer_cnt(xfer_cnt4),
    .occupancy(occupancy4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt();
    chk("xfer_cnt", 64'(xfer_cnt), 64'((m_cnt > 65535) ? 65535 : m_cnt));
    chk("xfer_cnt4", 64'(xfer_cnt4), 64'((m_cnt > 15) ? 15 : m_cnt));
  endtask

  // Drive one cycle: inputs set after the edge, checked at the falling edge,
  // scoreboard updated to match what the rising edge will commit.
  task automatic step(input logic avail, input logic [63:0] data,
                      input logic rdy, input logic fl);
    logic exp_rval, exp_val;
    in_data_avail = avail;
    in_data       = data;
    out_rdy       = rdy;
    flush         = fl;
    @(negedge clk);
    exp_rval = avail && (q.size() != 2) && !fl;
    exp_val  = (q.size() != 0);
    chk_cnt();
    chk("in_r_val", 64'(in_r_val), 64'(exp_rval));
    chk("out_val", 64'(out_val), 64'(exp_val));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    if (exp_val && rdy) begin
      chk("out_data", out_data, q[0]);
      void'(q.pop_front());
      m_cnt++;
    end
    if (fl) q.delete();
    else if (exp_rval) q.push_back(data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_data_avail = 1'b1; in_data = 64'h11; out_rdy = 1'b1;
    m_cnt = 0;
    #3;
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_out_val", 64'(out_val), 64'd0);
    chk("rst_out_data", out_data, '1);
    chk("rst_in_r_val", 64'(in_r_val), 64'd0);
    chk_cnt();
    @(posedge clk); #1;
    rst = 1'b0;

    // First word: pop in cycle 0, visible in cycle 1
    step(1'b1, 64'h11, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);

    // Back-to-back streaming
    for (int i = 1; i <= 8; i++) step(1'b1, 64'(i), 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);

    // Stall fills both entries, third word waits
    step(1'b1, 64'hA, 1'b0, 1'b0);
    step(1'b1, 64'hB, 1'b0, 1'b0);
    step(1'b1, 64'hC, 1'b0, 1'b0);
    step(1'b1, 64'hC, 1'b1, 1'b0);
    step(1'b1, 64'hC, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);

    // Flush at occupancy 2 with a concurrent pop
    step(1'b1, 64'h5, 1'b0, 1'b0);
    step(1'b1, 64'h6, 1'b0, 1'b0);
    step(1'b1, 64'h7, 1'b1, 1'b1);
    step(1'b0, 64'h0, 1'b1, 1'b0);

    // Enough transfers to saturate the narrow counter
    for (int i = 0; i < 20; i++) step(1'b1, 64'h100 + 64'(i), 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0));

    // Fill to occupancy 2, then async reset mid-cycle
    step(1'b0, 64'h0, 1'b1, 1'b1);
    step(1'b1, 64'h21, 1'b0, 1'b0);
    step(1'b1, 64'h22, 1'b0, 1'b0);
    chk("pre_rst_occupancy", 64'(occupancy), 64'd2);
    in_data_avail = 1'b1; out_rdy = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("async_out_val", 64'(out_val), 64'd0);
    chk("async_occupancy", 64'(occupancy), 64'd0);
    chk("async_xfer_cnt", 64'(xfer_cnt), 64'd0);
    chk("async_in_r_val", 64'(in_r_val), 64'd0);
    q.delete();
    m_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b1, 64'h33, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
